// File: rtl/ether_hdr_strip_if.sv
// ----------------------------------------------------------------------------
// ether_hdr_strip_if
// Streaming bus bundle shared by the input and payload sides of
// ether_hdr_strip.
//   data  : DATA_W beat, byte 0 in the top byte
//   valid : beat present
//   sop   : first beat of a frame
//   eop   : last beat of a frame
//   mty   : empty bytes in the eop beat
//   ready : sink can accept the beat
// The producer of a stream uses the master modport and the consumer uses the
// slave modport.
// ----------------------------------------------------------------------------
interface ether_hdr_strip_if #(
    parameter int DATA_W = 512
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              sop;
    logic              eop;
    logic [7:0]        mty;
    logic              ready;

    modport master (output data, valid, sop, eop, mty, input ready);
    modport slave  (input data, valid, sop, eop, mty, output ready);
endinterface

// File: rtl/ether_hdr_strip.sv
// ----------------------------------------------------------------------------
// ether_hdr_strip
// Removes the first HDR_BYTES bytes of each frame, presents them as a one-cycle
// header pulse, and re-aligns the remaining payload onto beat boundaries.
// Frames whose EtherType fails the masked compare against APP_KEY are dropped.
// Frames that carry nothing but a header are counted as runts.
// Ports:
//   clk, reset         : single clock, asynchronous active-high reset
//   recv               : input stream (slave side)
//   ether_data         : re-aligned payload stream (master side)
//   ether_header_data  : stripped header bytes, byte 0 in the top byte
//   ether_header_valid : one-cycle header pulse, not backpressured
//   pass_cnt, drop_cnt, runt_cnt : wrapping frame statistics
// ----------------------------------------------------------------------------
module ether_hdr_strip #(
    parameter int          DATA_W    = 512,
    parameter int          HDR_BYTES = 14,
    parameter logic [15:0] APP_KEY   = 16'h6000,
    parameter logic [15:0] KEY_MASK  = 16'hFFFF,
    parameter int          CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    ether_hdr_strip_if.slave       recv,
    ether_hdr_strip_if.master      ether_data,
    output logic [8*HDR_BYTES-1:0] ether_header_data,
    output logic                   ether_header_valid,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       runt_cnt
);
    localparam int B  = DATA_W / 8;
    localparam int P  = B - HDR_BYTES;
    localparam int HW = 8 * HDR_BYTES;
    localparam int PW = 8 * P;

    localparam logic [7:0] P_M = 8'(P);
    localparam logic [7:0] H_M = 8'(HDR_BYTES);
    localparam logic [7:0] B_M = 8'(B);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RECV_ALL = 2'd1;
    localparam logic [1:0] DROP     = 2'd2;
    localparam logic [1:0] LAST_ONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     buf_q, buf_d;
    logic              sop_pend_q, sop_pend_d;
    logic [7:0]        mty_reg_q, mty_reg_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic [7:0]        out_mty_q, out_mty_d;
    logic [HW-1:0]     hdr_data_q, hdr_data_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  runt_cnt_q, runt_cnt_d;

    logic          out_free;
    logic          recv_ready;
    logic          in_hs;
    logic [15:0]   key;
    logic          key_match;
    logic [HW-1:0] top_hdr;
    logic [PW-1:0] low_pay;
    logic [7:0]    sum_mty;

    // The output register may take a new beat when it is empty or draining
    // this cycle; input is refused while the flushed tail beat is pending.
    assign out_free   = !out_valid_q | ether_data.ready;
    assign recv_ready = (state_q != LAST_ONE) & out_free;
    assign in_hs      = recv.valid & recv_ready;

    assign key       = recv.data[DATA_W-HW +: 16];
    assign key_match = ((key ^ APP_KEY) & KEY_MASK) == 16'h0000;
    assign top_hdr   = recv.data[DATA_W-1 -: HW];
    assign low_pay   = recv.data[PW-1:0];
    assign sum_mty   = recv.mty + H_M;

    assign recv.ready         = recv_ready;
    assign ether_data.data    = out_data_q;
    assign ether_data.valid   = out_valid_q;
    assign ether_data.sop     = out_sop_q;
    assign ether_data.eop     = out_eop_q;
    assign ether_data.mty     = out_mty_q;
    assign ether_header_data  = hdr_data_q;
    assign ether_header_valid = hdr_valid_q;
    assign pass_cnt           = pass_cnt_q;
    assign drop_cnt           = drop_cnt_q;
    assign runt_cnt           = runt_cnt_q;

    // Frame FSM and output register load. Every payload beat is the previous
    // beat's low P bytes joined to the current beat's top HDR_BYTES bytes, so
    // buf carries the tail of the last accepted beat. An eop beat whose data
    // does not fit that window leaves a tail that is flushed from LAST_ONE.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        sop_pend_d  = sop_pend_q;
        mty_reg_d   = mty_reg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_mty_d   = out_mty_q;
        hdr_data_d  = hdr_data_q;
        hdr_valid_d = 1'b0;
        pass_cnt_d  = pass_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        runt_cnt_d  = runt_cnt_q;

        // A drained or empty register goes invalid unless reloaded below.
        if (out_free) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_hs && recv.sop) begin
                    if (!key_match) begin
                        drop_cnt_d = drop_cnt_q + CNT_ONE;
                        if (!recv.eop) begin
                            state_d = DROP;
                        end
                    end else if (!recv.eop) begin
                        hdr_valid_d = 1'b1;
                        hdr_data_d  = top_hdr;
                        buf_d       = low_pay;
                        sop_pend_d  = 1'b1;
                        state_d     = RECV_ALL;
                    end else if (sum_mty < B_M) begin
                        hdr_valid_d = 1'b1;
                        hdr_data_d  = top_hdr;
                        out_valid_d = 1'b1;
                        out_data_d  = {low_pay, {HW{1'b0}}};
                        out_sop_d   = 1'b1;
                        out_eop_d   = 1'b1;
                        out_mty_d   = sum_mty;
                        pass_cnt_d  = pass_cnt_q + CNT_ONE;
                    end else begin
                        runt_cnt_d = runt_cnt_q + CNT_ONE;
                    end
                end
            end
            RECV_ALL: begin
                if (in_hs) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {buf_q, top_hdr};
                    out_sop_d   = sop_pend_q;
                    out_eop_d   = 1'b0;
                    out_mty_d   = 8'd0;
                    sop_pend_d  = 1'b0;
                    buf_d       = low_pay;
                    if (recv.eop) begin
                        if (recv.mty >= P_M) begin
                            out_eop_d  = 1'b1;
                            out_mty_d  = recv.mty - P_M;
                            pass_cnt_d = pass_cnt_q + CNT_ONE;
                            state_d    = IDLE;
                        end else begin
                            mty_reg_d = sum_mty;
                            state_d   = LAST_ONE;
                        end
                    end
                end
            end
            LAST_ONE: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {buf_q, {HW{1'b0}}};
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b1;
                    out_mty_d   = mty_reg_q;
                    pass_cnt_d  = pass_cnt_q + CNT_ONE;
                    state_d     = IDLE;
                end
            end
            default: begin
                if (in_hs && recv.eop) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            sop_pend_q  <= 1'b0;
            mty_reg_q   <= 8'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_mty_q   <= 8'd0;
            hdr_data_q  <= '0;
            hdr_valid_q <= 1'b0;
            pass_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            sop_pend_q  <= sop_pend_d;
            mty_reg_q   <= mty_reg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_mty_q   <= out_mty_d;
            hdr_data_q  <= hdr_data_d;
            hdr_valid_q <= hdr_valid_d;
            pass_cnt_q  <= pass_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end
endmodule

// File: tb/tb_ether_hdr_strip.sv
// ----------------------------------------------------------------------------
// tb_ether_hdr_strip
// Drives whole frames into ether_hdr_strip with default parameters. Each frame
// is built as a byte array; the expected header and payload beats come from
// re-slicing that byte array after the first 14 bytes, and are queued for an
// independent monitor that pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_ether_hdr_strip;
    localparam int DW = 512;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [7:0]    mty;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [111:0]  hdr_data;
    logic          hdr_valid;
    logic [31:0]   pass_cnt;
    logic [31:0]   drop_cnt;
    logic [31:0]   runt_cnt;

    ether_hdr_strip_if #(.DATA_W(DW)) recv_if ();
    ether_hdr_strip_if #(.DATA_W(DW)) out_if ();

    ether_hdr_strip dut (
        .clk                (clk),
        .reset              (reset),
        .recv               (recv_if),
        .ether_data         (out_if),
        .ether_header_data  (hdr_data),
        .ether_header_valid (hdr_valid),
        .pass_cnt           (pass_cnt),
        .drop_cnt           (drop_cnt),
        .runt_cnt           (runt_cnt)
    );

    int total = 0;
    int bad = 0;
    int exp_pass = 0;
    int exp_drop = 0;
    int exp_runt = 0;
    bit stall_en = 0;

    beat_t        exp_q[$];
    logic [111:0] hdr_q[$];
    logic [7:0]   fb[0:511];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backpressure generator, random only while stalls are enabled.
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every payload handshake and header pulse against the
    // queued expectations and checks that a stalled beat stays put.
    initial begin
        beat_t e;
        beat_t held;
        bit    stalled;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    checkOutput("hold_data", out_if.data, held.data);
                    checkOutput("hold_ctl", {out_if.valid, out_if.sop, out_if.eop, out_if.mty},
                                {1'b1, held.sop, held.eop, held.mty});
                end
                if (out_if.valid && out_if.ready) begin
                    stalled = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_beat got=%h exp=none", out_if.data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_data", out_if.data, e.data);
                        checkOutput("beat_ctl", {out_if.sop, out_if.eop, out_if.mty}, {e.sop, e.eop, e.mty});
                    end
                end else if (out_if.valid) begin
                    stalled   = 1;
                    held.data = out_if.data;
                    held.sop  = out_if.sop;
                    held.eop  = out_if.eop;
                    held.mty  = out_if.mty;
                end else begin
                    stalled = 0;
                end
                if (hdr_valid) begin
                    if (hdr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_header got=%h exp=none", hdr_data);
                    end else begin
                        checkOutput("header", hdr_data, hdr_q.pop_front());
                    end
                end
            end
        end
    end

    // Offers one input beat from posedge+1 and returns one step after the edge
    // on which it was taken.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic sop, input logic eop, input logic [7:0] mty);
        int n;
        recv_if.data  = d;
        recv_if.sop   = sop;
        recv_if.eop   = eop;
        recv_if.mty   = mty;
        recv_if.valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (recv_if.ready) break;
            n++;
            if (n > 1000) begin
                $display("[TB] FAIL recv_ready_timeout got=0 exp=1");
                $fatal(1, "[TB] input stuck");
            end
        end
        @(posedge clk);
        #1;
        recv_if.valid = 1'b0;
    endtask

    // Builds a frame, queues its expected results and drives it.
    task automatic sendFrame(input int nbeats, input int last_mty, input logic [15:0] key,
                             input int seed, input bit mid_sop);
        int len;
        int plen;
        int nout;
        int idx;
        beat_t e;
        logic [111:0] h;
        logic [DW-1:0] d;
        len = nbeats * 64 - last_mty;
        for (int i = 0; i < 512; i++) begin
            fb[i] = (i < len) ? 8'(seed * 37 + i * 5 + 1) : 8'h00;
        end
        fb[12] = key[15:8];
        fb[13] = key[7:0];
        if (key != 16'h6000) begin
            exp_drop++;
        end else if (len <= 14) begin
            exp_runt++;
        end else begin
            exp_pass++;
            for (int j = 0; j < 14; j++) h[111-8*j -: 8] = fb[j];
            hdr_q.push_back(h);
            plen = len - 14;
            nout = (plen + 63) / 64;
            for (int k = 0; k < nout; k++) begin
                for (int j = 0; j < 64; j++) begin
                    idx = 14 + 64 * k + j;
                    e.data[DW-1-8*j -: 8] = (idx < len) ? fb[idx] : 8'h00;
                end
                e.sop = (k == 0);
                e.eop = (k == nout - 1);
                e.mty = (k == nout - 1) ? 8'(nout * 64 - plen) : 8'd0;
                exp_q.push_back(e);
            end
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int j = 0; j < 64; j++) d[DW-1-8*j -: 8] = fb[64*b+j];
            applyStimulus(d, (b == 0) || (mid_sop && b == 1), b == nbeats - 1,
                          (b == nbeats - 1) ? 8'(last_mty) : 8'd0);
        end
    endtask

    task automatic drainAndCount();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_left", exp_q.size() + hdr_q.size(), 0);
        checkOutput("pass_cnt", pass_cnt, exp_pass);
        checkOutput("drop_cnt", drop_cnt, exp_drop);
        checkOutput("runt_cnt", runt_cnt, exp_runt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout got=running exp=done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int nb_tab[10]  = '{1, 2, 3, 4, 5, 2, 3, 1, 4, 2};
        int mty_tab[10] = '{10, 60, 49, 50, 0, 63, 5, 30, 14, 40};

        reset         = 1'b1;
        recv_if.valid = 1'b0;
        recv_if.data  = '0;
        recv_if.sop   = 1'b0;
        recv_if.eop   = 1'b0;
        recv_if.mty   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", recv_if.ready, 1);
        checkOutput("rst_out", {out_if.valid, out_if.sop, out_if.eop, out_if.mty, hdr_valid}, 0);
        checkOutput("rst_data", out_if.data, 0);
        checkOutput("rst_cnts", {pass_cnt, drop_cnt, runt_cnt}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed frames, no backpressure");
        sendFrame(1, 20, 16'h6000, 1, 0);
        sendFrame(3, 60, 16'h6000, 2, 0);
        @(negedge clk);
        checkOutput("no_last_one_ready", recv_if.ready, 1);
        @(posedge clk);
        #1;
        sendFrame(3, 8, 16'h6000, 3, 0);
        @(negedge clk);
        checkOutput("last_one_ready_lo", recv_if.ready, 0);
        @(negedge clk);
        checkOutput("last_one_ready_hi", recv_if.ready, 1);
        @(posedge clk);
        #1;
        sendFrame(4, 0, 16'h0800, 4, 0);
        sendFrame(2, 30, 16'h6000, 5, 0);
        sendFrame(1, 52, 16'h6000, 6, 0);
        sendFrame(1, 50, 16'h6000, 7, 0);
        sendFrame(1, 49, 16'h6000, 8, 0);
        applyStimulus({DW{1'b1}}, 1'b0, 1'b1, 8'd0);
        sendFrame(1, 5, 16'h86DD, 9, 0);
        sendFrame(3, 50, 16'h6000, 10, 1);
        drainAndCount();

        $display("[TB] table frames with random backpressure");
        stall_en = 1;
        for (int f = 0; f < 10; f++) begin
            sendFrame(nb_tab[f], mty_tab[f], 16'h6000, 20 + f, 0);
        end
        drainAndCount();
        stall_en = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset in the middle of a frame");
        sendFrame(1, 0, 16'h6000, 40, 0);
        drainAndCount();
        for (int j = 0; j < 64; j++) fb[j] = 8'(j + 3);
        fb[12] = 8'h60;
        fb[13] = 8'h00;
        begin
            logic [111:0] h;
            logic [DW-1:0] d;
            for (int j = 0; j < 14; j++) h[111-8*j -: 8] = fb[j];
            for (int j = 0; j < 64; j++) d[DW-1-8*j -: 8] = fb[j];
            hdr_q.push_back(h);
            applyStimulus(d, 1'b1, 1'b0, 8'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out", {out_if.valid, out_if.sop, out_if.eop, out_if.mty, hdr_valid}, 0);
        checkOutput("midrst_data", {out_if.data, hdr_data}, 0);
        checkOutput("midrst_cnts", {pass_cnt, drop_cnt, runt_cnt}, 0);
        checkOutput("midrst_ready", recv_if.ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_pass = 0;
        exp_drop = 0;
        exp_runt = 0;
        @(posedge clk);
        #1;
        sendFrame(2, 20, 16'h6000, 41, 0);
        drainAndCount();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ether_hdr_strip.md
ETHER_HDR_STRIP -- requirements
Module: ether_hdr_strip

Interface
REQ-001 Parameters (name, default, meaning): DATA_W 512 stream width in bits (multiple of 8); HDR_BYTES 14 header bytes stripped (2..DATA_W/8-2); APP_KEY 16'h6000 EtherType match value; KEY_MASK 16'hFFFF EtherType compare mask; CNT_W 32 statistics counter width.
REQ-002 Derived: B = DATA_W/8 bytes per beat; P = B-HDR_BYTES payload bytes carried in the first beat; byte 0 of a beat occupies bits [DATA_W-1:DATA_W-8].
REQ-003 Clock: clk, input, 1, single clock; all logic on rising edge.
REQ-004 Reset: reset, input, 1, asynchronous, active-high.
REQ-005 Input stream: recv_data in DATA_W; recv_valid in 1; recv_sop in 1; recv_eop in 1; recv_mty in 8, empty bytes in the eop beat; recv_ready out 1.
REQ-006 Header output: ether_header_data out 8*HDR_BYTES, first HDR_BYTES bytes of the frame; ether_header_valid out 1, one-cycle pulse, not backpressured.
REQ-007 Payload output: ether_data_data out DATA_W; ether_data_valid, ether_data_sop, ether_data_eop out 1 each; ether_data_mty out 8; ether_data_ready in 1.
REQ-008 Statistics outputs, each CNT_W bits: pass_cnt counts accepted frames; drop_cnt counts key-mismatch frames; runt_cnt counts header-only frames.

Function
REQ-009 Input handshake occurs when recv_valid & recv_ready; output handshake occurs when ether_data_valid & ether_data_ready.
REQ-010 recv_ready = (state != LAST_ONE) & (!ether_data_valid | ether_data_ready); it is registered-state-derived only and never depends on recv_valid.
REQ-011 Key = bytes HDR_BYTES-2..HDR_BYTES-1 of the sop beat, i.e. bits [DATA_W-8*HDR_BYTES+15 : DATA_W-8*HDR_BYTES]; match = ((key ^ APP_KEY) & KEY_MASK) == 0.
REQ-012 FSM states are IDLE, RECV_ALL, DROP, LAST_ONE; the reset state is IDLE.
REQ-013 IDLE, sop handshake with match and no eop: pulse the header; buf <= low P bytes; sop_pend <= 1; go to RECV_ALL; no payload beat is emitted.
REQ-014 IDLE, sop handshake with match and eop: if recv_mty+HDR_BYTES < B, pulse the header and emit one beat {low P bytes, HDR_BYTES zero bytes} with sop=eop=1, mty=recv_mty+HDR_BYTES, and increment pass_cnt; otherwise emit no payload and increment runt_cnt; stay in IDLE in either case.
REQ-015 IDLE, sop handshake with mismatch: increment drop_cnt; go to DROP if !eop, else stay in IDLE; no header pulse.
REQ-016 IDLE, beat without sop: discard it.
REQ-017 RECV_ALL handshake: emit {buf, top HDR_BYTES bytes of recv_data} with sop=sop_pend; clear sop_pend; buf <= low P bytes.
REQ-018 RECV_ALL eop with m=recv_mty: if m >= P, emit eop=1, mty=m-P, increment pass_cnt, go to IDLE; else emit eop=0, mty_reg <= m+HDR_BYTES, go to LAST_ONE.
REQ-019 LAST_ONE, when output is free (!valid | ready): emit {buf, HDR_BYTES zero bytes} with sop=0, eop=1, mty=mty_reg; increment pass_cnt; go to IDLE.
REQ-020 DROP: discard beats until an eop handshake, then go to IDLE.
REQ-021 Output register: load on (!valid | ready); when valid & !ready, all ether_data_* outputs SHALL hold stable; valid clears after a handshake with no new load.
REQ-022 recv_valid gaps in RECV_ALL SHALL insert no output beat and SHALL not alter the buffer.
REQ-023 mty arithmetic is 8-bit unsigned; ether_data_mty < B always holds.
REQ-024 Counters wrap to 0 at all-ones; a simultaneous increment of different counters is permitted.
REQ-025 A sop arriving in RECV_ALL is treated as a continuation beat, with its sop ignored; no abort is performed.

Reset
REQ-026 Reset asserted: state=IDLE; every output and internal register (buf, mty_reg, sop_pend, counters) =0; recv_ready reads 1 after reset.
REQ-027 Reset mid-frame SHALL discard the partial frame with no eop emitted; the first beat after release is processed from IDLE.

Verification
REQ-028 Defaults, 1-beat frame, key 16'h6000, mty=20 -> header pulse; one beat with sop=eop=1, mty=34, low 50 bytes followed by 14 zero bytes; pass_cnt=1.
REQ-029 3-beat frame, last mty=60 -> 2 output beats; the second has eop=1, mty=10; LAST_ONE is not entered.
REQ-030 3-beat frame, last mty=8 -> 3 output beats; the third is {buf, 0}, eop=1, mty=22; recv_ready=0 for exactly one cycle.
REQ-031 Key 16'h0800 with KEY_MASK=16'hFFFF, 4 beats -> no output and no header pulse; drop_cnt=1; the next matching frame passes.
REQ-032 Random ether_data_ready stalls on 10 frames -> output data, sop, eop and mty match the reference model; no beat is lost or duplicated; outputs hold stable during stalls.
REQ-033 1-beat frame with mty=52 -> no payload emitted; runt_cnt=1; reset asserted mid-frame -> all outputs 0 and state=IDLE.
